gen3_descramble_ctrl: RTL and testbench
=======================================

# gen3_descramble_ctrl

Sequences the Gen3 (128b/130b) receive descrambler on a 32-bit, 4-symbol-per-beat PIPE datapath. It tracks block boundaries and the symbol index within each block, and classifies each block as Data, Ordered Set, SKP or EIEOS. From that it drives per-symbol bypass, LFSR advance/hold and LFSR re-seed controls to the lane descrambler, with data realigned alongside. It sits between the block aligner (sync header extraction) and the per-lane descrambler.

## Interface
- No parameters (fixed 32-bit, 4 symbols/beat; byte 0 = `data_i[7:0]` = earliest symbol).
- `clk_i` in 1: PIPE receive clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `valid_i` in 1: beat valid.
- `block_start_i` in 1: beat carries symbols 0–3 of a new block; qualified by `valid_i`.
- `sync_header_i` in 2: sync header; sampled only on block-start beats.
- `data_i` in 32: four received (scrambled) symbols.
- `valid_o` out 1: registered `valid_i`.
- `data_o` out 32: `data_i` delayed one cycle.
- `bypass_o` out 4: per-byte; 1 = descrambler must not XOR this symbol.
- `lfsr_advance_o` out 1: descrambler advances its LFSR by 4 symbols this beat.
- `lfsr_seed_o` out 1: descrambler loads the lane seed after this beat.
- `blk_type_o` out 3: `blk_type_e` of the current block.
- `sym_idx_o` out 4: block symbol index of byte 0 (0, 4, 8, 12; SKP up to 20 saturates at 12).
- `sds_o` out 1: pulse on the first beat of an SDS block.
- `err_o` out 1: pulse on a framing error.

## Operation
- FSM states: `UNALIGNED`, `DATA`, `OS`, `SKP`, `EIEOS`.
- A 2-bit beat counter clears on each valid block-start beat and increments on each other valid beat.
- On a block-start beat, the state is chosen as follows:
  - Sync header 01 → `DATA`.
  - Sync header 10 with symbol 0 = `GEN3_SKP` (0xAA) → `SKP`.
  - Symbol 0 = `EIEOS_SYM` (0x00) → `EIEOS`.
  - Any other symbol 0 → `OS`. If symbol 0 = `SDS_SYM` (0xE1), also pulse `sds_o`.
  - Sync header 00 or 11 → `UNALIGNED` and pulse `err_o`.
- `DATA`: bypass 0000, advance 1.
- `OS` (TS1/TS2/FTS/EIOS/SDS): advance 1.
  - Symbol 0 is bypassed.
  - FTS, EIOS and SDS bypass all symbols.
  - TS1/TS2 symbols 14 and 15 are bypassed only if the received value is in `DC_BAL_SYMS` {0x20, 0xDF, 0x08, 0xF7}.
- `SKP`: bypass 1111, advance 0 on every beat.
  - The block is variable length. It ends on the beat whose byte 0 = `SKP_END` (0xE1); that beat is the final beat of the block.
  - The next valid beat must be a block start.
- `EIEOS`: bypass 1111, advance 1. On beat 3, `lfsr_seed_o` = 1.
- `UNALIGNED`: bypass 1111, advance 0. Exit only on a block start.
- Framing errors pulse `err_o` and move to `UNALIGNED`:
  - `block_start_i` when the beat counter is not 3 (not after `SKP_END` in `SKP`).
  - A non-start beat after beat 3 or after `SKP_END`.
- Invalid beats (`valid_i` = 0) do not change state or counters; all controls output 0.

## Timing
- All outputs are registered; latency is 1 cycle from the input beat to the matching `data_o` and controls.
- Reset values: `valid_o`, `bypass_o`, `lfsr_advance_o`, `lfsr_seed_o`, `sds_o`, `err_o`, `blk_type_o` (`BLK_NONE`), `sym_idx_o` = 0; `data_o` = 0; FSM = `UNALIGNED`.
- A reset asserted mid-block aborts immediately. After release, the first block start re-aligns; no seed pulse is issued.
- `block_start_i` together with a framing error on the same beat: the error is flagged and the new block is still decoded (re-align on the same beat).
- SKP past 24 symbols (6 beats) without `SKP_END` is an error only when the feature below is compiled in.

## Configuration
- `GEN3_DESCR_CTRL_SKP_LEN_CHECK_EN`:
  - Defined: a 3-bit SKP beat counter enforces a maximum of 6 beats. A seventh beat without `SKP_END` pulses `err_o` and forces `UNALIGNED`.
  - Undefined: the counter and check are absent and SKP length is unbounded.

## Structure
- Shared package `pcie_phy_pkg` gains:
  - `blk_type_e`: `BLK_NONE`, `BLK_DATA`, `BLK_OS`, `BLK_SKP`, `BLK_EIEOS`.
  - Constants `GEN3_SKP`, `SKP_END`, `EIEOS_SYM`, `SDS_SYM`, `TS1OS`, `TS2OS`, `FTS_SYM` (0x55), `EIOS_SYM` (0x66), `DC_BAL_SYMS`.
- One sub-module: `gen3_os_classify`, combinational. It maps symbol 0 plus sync header to `blk_type_e` and an SDS flag.

## Test plan
- Four `DATA` blocks back-to-back, sync header 01 → bypass 0000, advance 1 every beat, `sym_idx_o` 0/4/8/12, no `err_o`.
- TS1 block with symbol 0 = 0x1E and symbols 14/15 = 0xDF 0xDF → bypass 0001 on beat 0, 1100 on beat 3, 0000 on beats 1–2.
- SKP block of 12 symbols (0xAA ×8, then 0xE1 in byte 0 of beat 2) followed by a data block → advance 0 for 3 beats, then `DATA` on the next start beat, no error.
- EIEOS (0x00/0xFF pattern) → bypass 1111 for 4 beats, `lfsr_seed_o` = 1 only on beat 3.
- `block_start_i` on beat 2 of a `DATA` block, then sync header 11 → `err_o` pulse on each beat; `UNALIGNED` until the next valid start.
- With `GEN3_DESCR_CTRL_SKP_LEN_CHECK_EN`: 7 beats of 0xAA → `err_o` on beat 7. Without the macro: no error, advance stays 0.

Source files
------------

// File: rtl/pcie_phy_pkg.sv
// Shared Gen3 PHY types, symbol constants and small symbol helpers.
package pcie_phy_pkg;

    typedef enum logic [2:0] {
        BLK_NONE  = 3'd0,
        BLK_DATA  = 3'd1,
        BLK_OS    = 3'd2,
        BLK_SKP   = 3'd3,
        BLK_EIEOS = 3'd4
    } blk_type_e;

    typedef enum logic [2:0] {
        UNALIGNED,
        DATA,
        OS,
        SKP,
        EIEOS
    } dscr_state_e;

    localparam logic [7:0] GEN3_SKP  = 8'hAA;
    localparam logic [7:0] SKP_END   = 8'hE1;
    localparam logic [7:0] EIEOS_SYM = 8'h00;
    localparam logic [7:0] SDS_SYM   = 8'hE1;
    localparam logic [7:0] TS1OS     = 8'h1E;
    localparam logic [7:0] TS2OS     = 8'h2D;
    localparam logic [7:0] FTS_SYM   = 8'h55;
    localparam logic [7:0] EIOS_SYM  = 8'h66;

    localparam logic [31:0] DC_BAL_SYMS = {8'h20, 8'hDF, 8'h08, 8'hF7};

    function automatic logic is_dc_bal(input logic [7:0] sym);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (sym == DC_BAL_SYMS[i*8 +: 8]) hit = 1'b1;
        end
        return hit;
    endfunction

    // These ordered sets carry no scrambled payload at all.
    function automatic logic os_full_bypass(input logic [7:0] sym0);
        return (sym0 == FTS_SYM) || (sym0 == EIOS_SYM) || (sym0 == SDS_SYM);
    endfunction

endpackage

// File: rtl/gen3_os_classify.sv
// Combinational block classifier: sync header plus symbol 0 to block type,
// SDS flag and illegal-header flag.
module gen3_os_classify
    import pcie_phy_pkg::*;
(
    input  logic [1:0] sync_hdr,
    input  logic [7:0] sym0,
    output blk_type_e  blk_type,
    output logic       sds,
    output logic       hdr_err
);

    always_comb begin
        blk_type = BLK_NONE;
        sds      = 1'b0;
        hdr_err  = 1'b0;
        unique case (sync_hdr)
            2'b01: blk_type = BLK_DATA;
            2'b10: begin
                if (sym0 == GEN3_SKP) begin
                    blk_type = BLK_SKP;
                end else if (sym0 == EIEOS_SYM) begin
                    blk_type = BLK_EIEOS;
                end else begin
                    blk_type = BLK_OS;
                    sds      = (sym0 == SDS_SYM);
                end
            end
            default: hdr_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/gen3_descramble_ctrl.sv
// Gen3 128b/130b receive descrambler sequencer (bypass/advance/seed per beat).
// Optional SKP length limit: GEN3_DESCR_CTRL_SKP_LEN_CHECK_EN.
module gen3_descramble_ctrl
    import pcie_phy_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic        block_start_i,
    input  logic [1:0]  sync_header_i,
    input  logic [31:0] data_i,
    output logic        valid_o,
    output logic [31:0] data_o,
    output logic [3:0]  bypass_o,
    output logic        lfsr_advance_o,
    output logic        lfsr_seed_o,
    output logic [2:0]  blk_type_o,
    output logic [3:0]  sym_idx_o,
    output logic        sds_o,
    output logic        err_o
);

    dscr_state_e state_q, state_d, cur;
    logic [1:0]  cnt_q, cnt_d;
    logic        skp_done_q, skp_done_d;
    logic        os_all_q, os_all_d;
    logic        frame_err;
    blk_type_e   cls_type;
    logic        cls_sds, cls_err;
    logic [3:0]  byp_d, idx_d;
    logic [2:0]  blk_d;
    logic        adv_d, seed_d, sds_d, err_d;
`ifdef GEN3_DESCR_CTRL_SKP_LEN_CHECK_EN
    logic [2:0]  skp_len_q, skp_len_d;
`endif

    gen3_os_classify u_cls (
        .sync_hdr (sync_header_i),
        .sym0     (data_i[7:0]),
        .blk_type (cls_type),
        .sds      (cls_sds),
        .hdr_err  (cls_err)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        skp_done_d = skp_done_q;
        os_all_d   = os_all_q;
        frame_err  = 1'b0;
        cur        = state_q;
        byp_d      = 4'h0;
        adv_d      = 1'b0;
        seed_d     = 1'b0;
        sds_d      = 1'b0;
        err_d      = 1'b0;
        blk_d      = blk_type_o;
        idx_d      = sym_idx_o;
`ifdef GEN3_DESCR_CTRL_SKP_LEN_CHECK_EN
        skp_len_d  = skp_len_q;
`endif
        if (valid_i) begin
            if (block_start_i) begin
                if (state_q == SKP) frame_err = !skp_done_q;
                else if (state_q != UNALIGNED) frame_err = (cnt_q != 2'd3);
                cnt_d      = 2'd0;
                skp_done_d = 1'b0;
                os_all_d   = os_full_bypass(data_i[7:0]);
                unique case (cls_type)
                    BLK_DATA:  state_d = DATA;
                    BLK_OS:    state_d = OS;
                    BLK_SKP:   state_d = SKP;
                    BLK_EIEOS: state_d = EIEOS;
                    default:   state_d = UNALIGNED;
                endcase
                sds_d = cls_sds;
                err_d = frame_err | cls_err;
`ifdef GEN3_DESCR_CTRL_SKP_LEN_CHECK_EN
                skp_len_d = 3'd1;
`endif
            end else begin
                if (state_q == SKP) frame_err = skp_done_q;
                else if (state_q != UNALIGNED) frame_err = (cnt_q == 2'd3);
`ifdef GEN3_DESCR_CTRL_SKP_LEN_CHECK_EN
                if (state_q == SKP && !skp_done_q) begin
                    if (skp_len_q == 3'd6) frame_err = (data_i[7:0] != SKP_END);
                    else skp_len_d = skp_len_q + 3'd1;
                end
`endif
                // Saturate so long SKP blocks report index 12.
                if (cnt_q != 2'd3) cnt_d = cnt_q + 2'd1;
                if (state_q == SKP && data_i[7:0] == SKP_END) skp_done_d = 1'b1;
                if (frame_err) state_d = UNALIGNED;
                err_d = frame_err;
            end
            cur   = state_d;
            idx_d = {cnt_d, 2'b00};
            unique case (cur)
                DATA: begin
                    adv_d = 1'b1;
                    blk_d = BLK_DATA;
                end
                OS: begin
                    adv_d = 1'b1;
                    blk_d = BLK_OS;
                    if (os_all_d) begin
                        byp_d = 4'hF;
                    end else if (cnt_d == 2'd0) begin
                        byp_d = 4'b0001;
                    end else if (cnt_d == 2'd3) begin
                        byp_d = {is_dc_bal(data_i[31:24]),
                                 is_dc_bal(data_i[23:16]), 2'b00};
                    end
                end
                SKP: begin
                    byp_d = 4'hF;
                    blk_d = BLK_SKP;
                end
                EIEOS: begin
                    byp_d  = 4'hF;
                    adv_d  = 1'b1;
                    blk_d  = BLK_EIEOS;
                    seed_d = (cnt_d == 2'd3);
                end
                default: begin
                    byp_d = 4'hF;
                    blk_d = BLK_NONE;
                    idx_d = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= UNALIGNED;
            cnt_q          <= 2'd0;
            skp_done_q     <= 1'b0;
            os_all_q       <= 1'b0;
            valid_o        <= 1'b0;
            data_o         <= 32'd0;
            bypass_o       <= 4'd0;
            lfsr_advance_o <= 1'b0;
            lfsr_seed_o    <= 1'b0;
            blk_type_o     <= BLK_NONE;
            sym_idx_o      <= 4'd0;
            sds_o          <= 1'b0;
            err_o          <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            skp_done_q     <= skp_done_d;
            os_all_q       <= os_all_d;
            valid_o        <= valid_i;
            data_o         <= data_i;
            bypass_o       <= byp_d;
            lfsr_advance_o <= adv_d;
            lfsr_seed_o    <= seed_d;
            blk_type_o     <= blk_d;
            sym_idx_o      <= idx_d;
            sds_o          <= sds_d;
            err_o          <= err_d;
        end
    end

`ifdef GEN3_DESCR_CTRL_SKP_LEN_CHECK_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) skp_len_q <= 3'd0;
        else       skp_len_q <= skp_len_d;
    end
`endif

endmodule

// File: tb/tb_gen3_descramble_ctrl.sv
// Directed self-checking bench for gen3_descramble_ctrl.
// Expected control words are hand-derived per beat.
module tb_gen3_descramble_ctrl;

    localparam logic [2:0] BN = 3'd0;
    localparam logic [2:0] BD = 3'd1;
    localparam logic [2:0] BO = 3'd2;
    localparam logic [2:0] BS = 3'd3;
    localparam logic [2:0] BE = 3'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        block_start = 1'b0;
    logic [1:0]  sync_header = 2'b00;
    logic [31:0] data = 32'd0;
    logic        valid_o;
    logic [31:0] data_o;
    logic [3:0]  bypass_o;
    logic        lfsr_advance_o;
    logic        lfsr_seed_o;
    logic [2:0]  blk_type_o;
    logic [3:0]  sym_idx_o;
    logic        sds_o;
    logic        err_o;
    logic [15:0] ctrl;
    logic [8:0]  pulses;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gen3_descramble_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .valid_i        (valid),
        .block_start_i  (block_start),
        .sync_header_i  (sync_header),
        .data_i         (data),
        .valid_o        (valid_o),
        .data_o         (data_o),
        .bypass_o       (bypass_o),
        .lfsr_advance_o (lfsr_advance_o),
        .lfsr_seed_o    (lfsr_seed_o),
        .blk_type_o     (blk_type_o),
        .sym_idx_o      (sym_idx_o),
        .sds_o          (sds_o),
        .err_o          (err_o)
    );

    assign ctrl = {valid_o, bypass_o, lfsr_advance_o, lfsr_seed_o,
                   blk_type_o, sym_idx_o, sds_o, err_o};
    assign pulses = {valid_o, bypass_o, lfsr_advance_o, lfsr_seed_o,
                     sds_o, err_o};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ex(input logic [3:0] byp, input logic adv,
                                       input logic seed, input logic [2:0] blk,
                                       input logic [3:0] idx, input logic sds,
                                       input logic err);
        return {1'b1, byp, adv, seed, blk, idx, sds, err};
    endfunction

    task automatic beat(input string tag, input logic st, input logic [1:0] hdr,
                        input logic [31:0] d, input logic [15:0] e);
        @(negedge clk);
        valid = 1'b1;
        block_start = st;
        sync_header = hdr;
        data = d;
        @(posedge clk);
        #1;
        chk(tag, {16'd0, ctrl}, {16'd0, e});
        chk({tag, "_d"}, data_o, d);
    endtask

    task automatic idle(input string tag);
        @(negedge clk);
        valid = 1'b0;
        block_start = 1'b1;
        sync_header = 2'b11;
        data = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        chk(tag, {23'd0, pulses}, 32'd0);
    endtask

    task automatic data_blk(input string tag);
        for (int k = 0; k < 4; k++)
            beat($sformatf("%s%0d", tag, k), k == 0, 2'b01, 32'h5A00_0000 + k,
                 ex(4'h0, 1'b1, 1'b0, BD, 4'(k * 4), 1'b0, 1'b0));
    endtask

    initial begin
        #12;
        chk("rst_ctrl", {16'd0, ctrl}, 32'd0);
        chk("rst_data", data_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Four back-to-back data blocks, one invalid beat inside the first
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 4; k++) begin
                if (b == 0 && k == 2) idle("idle_mid");
                beat($sformatf("data%0d_%0d", b, k), k == 0,
                     k == 0 ? 2'b01 : 2'b10, 32'hC0DE_0000 + 32'(b * 4 + k),
                     ex(4'h0, 1'b1, 1'b0, BD, 4'(k * 4), 1'b0, 1'b0));
            end
        end

        // TS1 with DC-balance symbols 14/15
        beat("ts1_0", 1'b1, 2'b10, 32'h4A4A_0A1E,
             ex(4'b0001, 1'b1, 1'b0, BO, 4'd0, 1'b0, 1'b0));
        beat("ts1_1", 1'b0, 2'b00, 32'h4A4A_4A4A,
             ex(4'b0000, 1'b1, 1'b0, BO, 4'd4, 1'b0, 1'b0));
        beat("ts1_2", 1'b0, 2'b00, 32'hDFDF_4A4A,
             ex(4'b0000, 1'b1, 1'b0, BO, 4'd8, 1'b0, 1'b0));
        beat("ts1_3", 1'b0, 2'b00, 32'hDFDF_4A4A,
             ex(4'b1100, 1'b1, 1'b0, BO, 4'd12, 1'b0, 1'b0));

        // 12-symbol SKP then data
        beat("skp_0", 1'b1, 2'b10, 32'hAAAA_AAAA,
             ex(4'hF, 1'b0, 1'b0, BS, 4'd0, 1'b0, 1'b0));
        beat("skp_1", 1'b0, 2'b00, 32'hAAAA_AAAA,
             ex(4'hF, 1'b0, 1'b0, BS, 4'd4, 1'b0, 1'b0));
        beat("skp_2", 1'b0, 2'b00, 32'h1234_56E1,
             ex(4'hF, 1'b0, 1'b0, BS, 4'd8, 1'b0, 1'b0));
        data_blk("skp_dat");

        // EIEOS
        for (int k = 0; k < 4; k++)
            beat($sformatf("eieos_%0d", k), k == 0, 2'b10, 32'hFF00_FF00,
                 ex(4'hF, 1'b1, k == 3, BE, 4'(k * 4), 1'b0, 1'b0));

        // SDS: pulse on first beat, everything bypassed
        for (int k = 0; k < 4; k++)
            beat($sformatf("sds_%0d", k), k == 0, 2'b10,
                 k == 0 ? 32'h5555_55E1 : 32'h5555_5555,
                 ex(4'hF, 1'b1, 1'b0, BO, 4'(k * 4), k == 0, 1'b0));

        // Early start on beat 2, then bad header
        data_blk("pre_e");
        beat("e_b0", 1'b1, 2'b01, 32'h0000_0001,
             ex(4'h0, 1'b1, 1'b0, BD, 4'd0, 1'b0, 1'b0));
        beat("e_b1", 1'b0, 2'b00, 32'h0000_0002,
             ex(4'h0, 1'b1, 1'b0, BD, 4'd4, 1'b0, 1'b0));
        beat("e_early", 1'b1, 2'b01, 32'h0000_0003,
             ex(4'h0, 1'b1, 1'b0, BD, 4'd0, 1'b0, 1'b1));
        beat("e_hdr11", 1'b1, 2'b11, 32'h0000_0004,
             ex(4'hF, 1'b0, 1'b0, BN, 4'd0, 1'b0, 1'b1));
        beat("e_unal", 1'b0, 2'b00, 32'h0000_0005,
             ex(4'hF, 1'b0, 1'b0, BN, 4'd0, 1'b0, 1'b0));
        data_blk("realign");

        // Non-start beat after beat 3
        beat("e_over", 1'b0, 2'b01, 32'h0000_0006,
             ex(4'hF, 1'b0, 1'b0, BN, 4'd0, 1'b0, 1'b1));
        data_blk("post_over");

        // Long SKP: seven beats without SKP_END
        for (int k = 0; k < 6; k++)
            beat($sformatf("lskp_%0d", k), k == 0, 2'b10, 32'hAAAA_AAAA,
                 ex(4'hF, 1'b0, 1'b0, BS, 4'(k > 3 ? 12 : k * 4), 1'b0, 1'b0));
`ifdef GEN3_DESCR_CTRL_SKP_LEN_CHECK_EN
        beat("lskp_6", 1'b0, 2'b00, 32'hAAAA_AAAA,
             ex(4'hF, 1'b0, 1'b0, BN, 4'd0, 1'b0, 1'b1));
        beat("lskp_end", 1'b0, 2'b00, 32'hAAAA_AAE1,
             ex(4'hF, 1'b0, 1'b0, BN, 4'd0, 1'b0, 1'b0));
`else
        beat("lskp_6", 1'b0, 2'b00, 32'hAAAA_AAAA,
             ex(4'hF, 1'b0, 1'b0, BS, 4'd12, 1'b0, 1'b0));
        beat("lskp_end", 1'b0, 2'b00, 32'hAAAA_AAE1,
             ex(4'hF, 1'b0, 1'b0, BS, 4'd12, 1'b0, 1'b0));
`endif
        data_blk("post_lskp");

        // Reset mid-EIEOS: aborts, no seed after release
        for (int k = 0; k < 3; k++)
            beat($sformatf("reie_%0d", k), k == 0, 2'b10, 32'hFF00_FF00,
                 ex(4'hF, 1'b1, 1'b0, BE, 4'(k * 4), 1'b0, 1'b0));
        @(negedge clk);
        valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid_ctrl", {16'd0, ctrl}, 32'd0);
        chk("rst_mid_data", data_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        beat("reie_3", 1'b0, 2'b00, 32'hFF00_FF00,
             ex(4'hF, 1'b0, 1'b0, BN, 4'd0, 1'b0, 1'b0));
        data_blk("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
